// File: rtl/fp_add_pipe.sv
// fp_add_pipe: 3-stage pipelined floating-point add/sub (unpack/align, add, normalise/pack)
// with IEEE specials and flags. FP_ADD_ROUND_RNE_EN selects round-to-nearest-even, else truncate.
module fp_add_pipe #(
    parameter int EXP_WIDTH  = 8,
    parameter int FRAC_WIDTH = 7,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              in_op,
    input  logic [EXP_WIDTH+FRAC_WIDTH:0]     in_a,
    input  logic [EXP_WIDTH+FRAC_WIDTH:0]     in_b,
    input  logic [TAG_WIDTH-1:0]              in_tag,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [EXP_WIDTH+FRAC_WIDTH:0]     out_result,
    output logic [TAG_WIDTH-1:0]              out_tag,
    output logic                              out_overflow,
    output logic                              out_underflow,
    output logic                              out_invalid
);
    localparam int W   = 1 + EXP_WIDTH + FRAC_WIDTH;
    localparam int M   = FRAC_WIDTH + 1;
    localparam int A   = FRAC_WIDTH + 4;
    localparam int LZW = $clog2(FRAC_WIDTH + 4);
    localparam int EW  = EXP_WIDTH + 2;
    localparam logic [EXP_WIDTH-1:0] EXP_MAX   = '1;
    localparam logic [EXP_WIDTH-1:0] SHIFT_MAX = EXP_WIDTH'(A - 1);
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(FRAC_WIDTH-1){1'b0}}};

    logic       adv;
    logic [2:0] vld_pipe;

    assign adv       = ~vld_pipe[2] | out_ready;
    assign in_ready  = adv | rst;
    assign out_valid = vld_pipe[2];

    always_ff @(posedge clk) begin
        if (rst)
            vld_pipe <= '0;
        else if (adv)
            vld_pipe <= {vld_pipe[1:0], in_valid};
    end

    // ---------------- S1: unpack, classify, align ----------------
    logic                  sa, sb;
    logic [EXP_WIDTH-1:0]  ea, eb;
    logic [FRAC_WIDTH-1:0] fa, fb;
    logic [W-1:0]          b_eff;
    logic                  za, zb, ia, ib, na, nb;

    assign sa    = in_a[W-1];
    assign ea    = in_a[W-2:FRAC_WIDTH];
    assign fa    = in_a[FRAC_WIDTH-1:0];
    assign sb    = in_b[W-1] ^ in_op;
    assign eb    = in_b[W-2:FRAC_WIDTH];
    assign fb    = in_b[FRAC_WIDTH-1:0];
    assign b_eff = {sb, eb, fb};
    assign za    = (ea == '0);
    assign zb    = (eb == '0);
    assign ia    = (ea == EXP_MAX) && (fa == '0);
    assign ib    = (eb == EXP_MAX) && (fb == '0);
    assign na    = (ea == EXP_MAX) && (fa != '0);
    assign nb    = (eb == EXP_MAX) && (fb != '0);

    logic         sp, sp_inv;
    logic [W-1:0] sp_res;

    always_comb begin
        sp     = 1'b1;
        sp_inv = 1'b0;
        sp_res = '0;
        if (na || nb) begin
            sp_res = QNAN;
            sp_inv = 1'b1;
        end else if (ia && ib && (sa != sb)) begin
            sp_res = QNAN;
            sp_inv = 1'b1;
        end else if (ia) begin
            sp_res = in_a;
        end else if (ib) begin
            sp_res = b_eff;
        end else if (za && zb) begin
            sp_res = {sa & sb, {(W-1){1'b0}}};
        end else if (za) begin
            sp_res = b_eff;
        end else if (zb) begin
            sp_res = in_a;
        end else begin
            sp = 1'b0;
        end
    end

    logic                  a_ge, big_s;
    logic [EXP_WIDTH-1:0]  big_e, sml_e, diff;
    logic [FRAC_WIDTH-1:0] big_f, sml_f;
    logic [A-1:0]          m_big, m_sml, sh, m_al;
    logic                  lost;

    assign a_ge  = {ea, fa} >= {eb, fb};
    assign big_s = a_ge ? sa : sb;
    assign big_e = a_ge ? ea : eb;
    assign big_f = a_ge ? fa : fb;
    assign sml_e = a_ge ? eb : ea;
    assign sml_f = a_ge ? fb : fa;
    assign diff  = big_e - sml_e;
    assign m_big = {1'b1, big_f, 3'b000};
    assign m_sml = {1'b1, sml_f, 3'b000};
    assign sh    = m_sml >> diff;
    assign lost  = |(m_sml & ~({A{1'b1}} << diff));
    // Far-shifted operand collapses to a lone sticky bit.
    assign m_al  = (diff >= SHIFT_MAX) ? {{(A-1){1'b0}}, 1'b1} : {sh[A-1:1], sh[0] | lost};

    logic                  s1_sign, s1_sub, s1_sp, s1_sp_inv;
    logic [EXP_WIDTH-1:0]  s1_exp;
    logic [A-1:0]          s1_big, s1_sml;
    logic [W-1:0]          s1_sp_res;
    logic [TAG_WIDTH-1:0]  s1_tag;

    // ---------------- S2: add / subtract ----------------
    logic [A:0]            sum;
    logic                  s2_sign, s2_sp, s2_sp_inv;
    logic [EXP_WIDTH-1:0]  s2_exp;
    logic [A:0]            s2_sum;
    logic [W-1:0]          s2_sp_res;
    logic [TAG_WIDTH-1:0]  s2_tag;

    assign sum = s1_sub ? ({1'b0, s1_big} - {1'b0, s1_sml}) : ({1'b0, s1_big} + {1'b0, s1_sml});

    always_ff @(posedge clk) begin
        if (adv) begin
            s1_sign   <= big_s;
            s1_exp    <= big_e;
            s1_big    <= m_big;
            s1_sml    <= m_al;
            s1_sub    <= sa ^ sb;
            s1_sp     <= sp;
            s1_sp_res <= sp_res;
            s1_sp_inv <= sp_inv;
            s1_tag    <= in_tag;
            s2_sign   <= s1_sign;
            s2_exp    <= s1_exp;
            s2_sum    <= sum;
            s2_sp     <= s1_sp;
            s2_sp_res <= s1_sp_res;
            s2_sp_inv <= s1_sp_inv;
            s2_tag    <= s1_tag;
        end
    end

    // ---------------- S3: normalise, round, pack ----------------
    logic [LZW-1:0] lz;
    logic [A-1:0]   nm;
    logic [EW-1:0]  e_n, e_r;
    logic [M-1:0]   mant;

    always_comb begin
        lz = '0;
        for (int i = 0; i < A; i++)
            if (s2_sum[i]) lz = LZW'(A - 1 - i);
    end

    always_comb begin
        if (s2_sum[A]) begin
            nm  = {s2_sum[A:2], s2_sum[1] | s2_sum[0]};
            e_n = {2'b00, s2_exp} + EW'(1);
        end else begin
            nm  = s2_sum[A-1:0] << lz;
            e_n = {2'b00, s2_exp} - EW'(lz);
        end
    end

`ifdef FP_ADD_ROUND_RNE_EN
    logic         rnd_up;
    logic [M:0]   mant_r;

    assign rnd_up = nm[2] & (nm[1] | nm[0] | nm[3]);
    assign mant_r = {1'b0, nm[A-1:3]} + {{M{1'b0}}, rnd_up};

    // Rounding 1.11..1 up carries out: renormalise by one more right shift.
    always_comb begin
        if (mant_r[M]) begin
            mant = mant_r[M:1];
            e_r  = e_n + EW'(1);
        end else begin
            mant = mant_r[M-1:0];
            e_r  = e_n;
        end
    end
`else
    logic unused_grs;

    assign unused_grs = ^nm[2:0];
    assign mant       = nm[A-1:3];
    assign e_r        = e_n;
`endif

    logic [W-1:0] res;
    logic         ovf, unf, inv;

    always_comb begin
        res = {s2_sign, e_r[EXP_WIDTH-1:0], mant[FRAC_WIDTH-1:0]};
        ovf = 1'b0;
        unf = 1'b0;
        inv = 1'b0;
        if (s2_sp) begin
            res = s2_sp_res;
            inv = s2_sp_inv;
        end else if (s2_sum == '0) begin
            res = '0;
        end else if (!e_r[EW-1] && (e_r[EW-2:0] >= {1'b0, EXP_MAX})) begin
            res = {s2_sign, EXP_MAX, {FRAC_WIDTH{1'b0}}};
            ovf = 1'b1;
        end else if (e_r[EW-1] || (e_r == '0)) begin
            res = {s2_sign, {(W-1){1'b0}}};
            unf = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_result    <= '0;
            out_tag       <= '0;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
            out_invalid   <= 1'b0;
        end else if (adv) begin
            out_result    <= res;
            out_tag       <= s2_tag;
            out_overflow  <= ovf;
            out_underflow <= unf;
            out_invalid   <= inv;
        end
    end
endmodule

// File: tb/tb_fp_add_pipe.sv
// Directed self-checking bench for fp_add_pipe (bf16 defaults); expectations follow FP_ADD_ROUND_RNE_EN.
module tb_fp_add_pipe;
`ifdef FP_ADD_ROUND_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, in_op, out_valid, out_ready;
    logic [15:0] in_a, in_b, out_result;
    logic [3:0]  in_tag, out_tag;
    logic        out_overflow, out_underflow, out_invalid;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    fp_add_pipe #(.EXP_WIDTH(8), .FRAC_WIDTH(7), .TAG_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag), .out_overflow(out_overflow),
        .out_underflow(out_underflow), .out_invalid(out_invalid)
    );

    // Drives one op and waits (bounded) for its result; lat counts rising edges incl. the handshake edge.
    task automatic issue_and_wait(input logic [15:0] a, input logic [15:0] b, input logic op,
                                  input logic [3:0] tag, output logic [15:0] r, output logic [3:0] t,
                                  output logic [2:0] f, output int lat);
        @(negedge clk);
        in_a = a; in_b = b; in_op = op; in_tag = tag; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        r = out_result; t = out_tag; f = {out_overflow, out_underflow, out_invalid};
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0; in_op = 1'b0; in_tag = '0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_result !== 16'h0 || out_tag !== 4'h0) begin
            failures++;
            $display("FAIL reset_out valid=%b result=%h tag=%h want 0/0000/0", out_valid, out_result, out_tag);
        end
        checks++;
        if ({out_overflow, out_underflow, out_invalid} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags got=%b want=000", {out_overflow, out_underflow, out_invalid});
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%b want=1", in_ready);
        end
        rst = 1'b0; out_ready = 1'b1;
    endtask

    task automatic test_basic();
        logic [15:0] r; logic [3:0] t; logic [2:0] f; int lat;
        issue_and_wait(16'h3F80, 16'h4000, 1'b0, 4'h5, r, t, f, lat);
        checks++;
        if (lat !== 3) begin failures++; $display("FAIL basic_latency got=%0d want=3", lat); end
        checks++;
        if (r !== 16'h4040) begin failures++; $display("FAIL basic_result got=%h want=4040", r); end
        checks++;
        if (t !== 4'h5) begin failures++; $display("FAIL basic_tag got=%h want=5", t); end
        checks++;
        if (f !== 3'b000) begin failures++; $display("FAIL basic_flags got=%b want=000", f); end
    endtask

    task automatic test_zero_cancel();
        logic [15:0] va [6] = '{16'h3F80, 16'h8000, 16'h0000, 16'h3F80, 16'h0000, 16'h8000};
        logic [15:0] vb [6] = '{16'h3F80, 16'h8000, 16'h4000, 16'h0000, 16'h0000, 16'h0000};
        logic        vo [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [15:0] vr [6] = '{16'h0000, 16'h8000, 16'h4000, 16'h3F80, 16'h0000, 16'h0000};
        logic [15:0] r; logic [3:0] t; logic [2:0] f; int lat;
        for (int i = 0; i < 6; i++) begin
            issue_and_wait(va[i], vb[i], vo[i], 4'(i + 1), r, t, f, lat);
            checks++;
            if (r !== vr[i] || f !== 3'b000 || t !== 4'(i + 1) || lat !== 3) begin
                failures++;
                $display("FAIL zero_cancel[%0d] got res=%h flags=%b tag=%h lat=%0d want res=%h flags=000 tag=%h lat=3",
                         i, r, f, t, lat, vr[i], 4'(i + 1));
            end
        end
    endtask

    task automatic test_specials();
        logic [15:0] va [7] = '{16'h7F7F, 16'h7F80, 16'h7F80, 16'h7FC1, 16'h7F80, 16'h3F80, 16'h0080};
        logic [15:0] vb [7] = '{16'h7F7F, 16'hFF80, 16'h7F80, 16'h3F80, 16'h3F80, 16'hFF80, 16'h0081};
        logic        vo [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [15:0] vr [7] = '{16'h7F80, 16'h7FC0, 16'h7FC0, 16'h7FC0, 16'h7F80, 16'hFF80, 16'h8000};
        logic [2:0]  vf [7] = '{3'b100, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000, 3'b010};
        logic [15:0] r; logic [3:0] t; logic [2:0] f; int lat;
        for (int i = 0; i < 7; i++) begin
            issue_and_wait(va[i], vb[i], vo[i], 4'(i + 8), r, t, f, lat);
            checks++;
            if (r !== vr[i] || f !== vf[i] || t !== 4'(i + 8) || lat !== 3) begin
                failures++;
                $display("FAIL specials[%0d] got res=%h flags=%b tag=%h lat=%0d want res=%h flags=%b tag=%h lat=3",
                         i, r, f, t, lat, vr[i], vf[i], 4'(i + 8));
            end
        end
    endtask

    task automatic test_rounding();
        logic [15:0] va [5] = '{16'h3F81, 16'h3F80, 16'h3F80, 16'h3F80, 16'h3FFF};
        logic [15:0] vb [5] = '{16'h3B80, 16'h3B80, 16'h3380, 16'h3BC0, 16'h3B80};
        logic [15:0] vr [5];
        logic [15:0] r; logic [3:0] t; logic [2:0] f; int lat;
        vr[0] = RNE ? 16'h3F82 : 16'h3F81;
        vr[1] = 16'h3F80;
        vr[2] = 16'h3F80;
        vr[3] = RNE ? 16'h3F81 : 16'h3F80;
        vr[4] = RNE ? 16'h4000 : 16'h3FFF;
        for (int i = 0; i < 5; i++) begin
            issue_and_wait(va[i], vb[i], 1'b0, 4'(i + 3), r, t, f, lat);
            checks++;
            if (r !== vr[i] || f !== 3'b000 || t !== 4'(i + 3) || lat !== 3) begin
                failures++;
                $display("FAIL rounding[%0d] got res=%h flags=%b tag=%h lat=%0d want res=%h flags=000 tag=%h lat=3",
                         i, r, f, t, lat, vr[i], 4'(i + 3));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] va [6] = '{16'h3F80, 16'h3F80, 16'h4000, 16'h7F80, 16'h0000, 16'h3F80};
        logic [15:0] vb [6] = '{16'h4000, 16'h3F80, 16'h4000, 16'h3F80, 16'h4000, 16'h3F80};
        logic        vo [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [15:0] vr [6] = '{16'h4040, 16'h0000, 16'h4080, 16'h7F80, 16'h4000, 16'h4000};
        int idx = 0, got = 0, cyc = 0, extra = 0;
        logic stalled = 1'b0;
        logic [15:0] held_r = '0;
        logic [3:0]  held_t = '0;
        while (got < 6 && cyc < 60) begin
            @(negedge clk);
            out_ready = !(cyc >= 4 && cyc < 8);
            in_valid  = (idx < 6);
            if (idx < 6) begin
                in_a = va[idx]; in_b = vb[idx]; in_op = vo[idx]; in_tag = 4'(idx + 10);
            end
            #1;
            if (out_valid && !out_ready) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_stall_in_ready cyc=%0d got=%b want=0", cyc, in_ready);
                end
            end
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || out_result !== held_r || out_tag !== held_t) begin
                    failures++;
                    $display("FAIL b2b_stable cyc=%0d got v=%b res=%h tag=%h want v=1 res=%h tag=%h",
                             cyc, out_valid, out_result, out_tag, held_r, held_t);
                end
            end
            stalled = out_valid && !out_ready;
            held_r  = out_result;
            held_t  = out_tag;
            if (out_valid && out_ready) begin
                checks++;
                if (out_result !== vr[got] || out_tag !== 4'(got + 10)) begin
                    failures++;
                    $display("FAIL b2b_result[%0d] got res=%h tag=%h want res=%h tag=%h",
                             got, out_result, out_tag, vr[got], 4'(got + 10));
                end
                got++;
            end
            if (in_valid && in_ready) idx++;
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        checks++;
        if (got !== 6) begin failures++; $display("FAIL b2b_count got=%0d want=6", got); end
        for (int i = 0; i < 5; i++) begin
            #1;
            if (out_valid) extra++;
            @(negedge clk);
        end
        checks++;
        if (extra !== 0) begin failures++; $display("FAIL b2b_duplicates got=%0d want=0", extra); end
    endtask

    task automatic test_reset_midflight();
        logic [15:0] r; logic [3:0] t; logic [2:0] f; int lat;
        int seen = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_a = 16'h3F80; in_b = 16'h4000; in_op = 1'b0; in_tag = 4'(i + 1); in_valid = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL midrst_inflight got=%b want=1", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready got=%b want=1", in_ready); end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_result !== 16'h0) begin
            failures++;
            $display("FAIL midrst_cleared got v=%b res=%h want v=0 res=0000", out_valid, out_result);
        end
        rst = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin failures++; $display("FAIL midrst_stale got=%0d want=0", seen); end
        issue_and_wait(16'h3F80, 16'h3F80, 1'b0, 4'h9, r, t, f, lat);
        checks++;
        if (r !== 16'h4000 || t !== 4'h9 || f !== 3'b000 || lat !== 3) begin
            failures++;
            $display("FAIL midrst_first_op got res=%h tag=%h flags=%b lat=%0d want res=4000 tag=9 flags=000 lat=3",
                     r, t, f, lat);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_cancel();
        test_specials();
        test_rounding();
        test_back_to_back();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
